// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer
//   WIDTH-bit add/subtract built from a single 4-bit ripple slice that is
//   reused over N = WIDTH/4 cycles, least significant nibble first. The
//   inter-nibble carry lives in carry_q, so the critical path is one nibble
//   ripple regardless of WIDTH.
//
//   WIDTH must be a multiple of 4 and at least 4.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active low
//   start  in   request, sampled only in IDLE
//   sub    in   0: a+b+cin, 1: a-b (cin ignored), sampled with start
//   a, b   in   operands, sampled with start
//   cin    in   add carry-in, sampled with start
//   busy   out  high during the N RUN cycles
//   done   out  one-cycle pulse, sum/cout/ovf final in that cycle
//   sum    out  result (fills nibble by nibble, valid only with done)
//   cout   out  carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  two's-complement signed overflow
module multiword_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SEL_W = IDX_W + 2;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    // Slice datapath: one 4-bit adder, 5-bit result {carry, sum}.
    logic [SEL_W-1:0]   lsb_sel;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [4:0]         slice_d;
    logic               last_d;
    logic               ovf_d;

    always_comb begin
        lsb_sel = {idx_q, 2'b00};
        a_nib   = a_q[lsb_sel +: 4];
        b_nib   = b_q[lsb_sel +: 4];
        slice_d = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        last_d  = (idx_q == IDX_W'(N - 1));
        // b_q already holds ~b for subtract, so this is the plain same-sign
        // rule on the effective operands.
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_d[3] != a_q[WIDTH-1]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        // Subtract is a + ~b + 1: invert b once here and
                        // seed the carry, so the slice only ever adds.
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q[lsb_sel +: 4] <= slice_d[3:0];
                    carry_q             <= slice_d[4];
                    if (last_d) begin
                        cout_q  <= slice_d[4];
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here; it is never queued.
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer (WIDTH=16). The driver pushes the
// hand-computed result for each accepted request into a scoreboard queue;
// a monitor pops and compares whenever done is seen.
module tb_multiword_add_sequencer;

    localparam int W = 16;
    localparam int N = W / 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   busy_cnt;
    exp_t sb[$];

    multiword_add_sequencer #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .sub  (sub),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs forever in the background; samples on the falling edge.
    task automatic monitor();
        exp_t e;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    if (sb.size() == 0) begin
                        check("spurious_done", 32'(done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("sum",        32'(sum),  32'(e.sum));
                        check("cout",       32'(cout), 32'(e.cout));
                        check("ovf",        32'(ovf),  32'(e.ovf));
                        check("latency",    32'(cyc),  32'(e.cyc));
                        check("busy_cycles", 32'(busy_cnt), 32'(N));
                        check("busy_at_done", 32'(busy), 32'd0);
                    end
                    busy_cnt = 0;
                end
            end
        end
    endtask

    // Called at posedge+1 while IDLE; leaves start low after the accepting edge.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        e.sum = es; e.cout = ec; e.ovf = eo; e.cyc = cyc + 1 + N;
        sb.push_back(e);
        a = ia; b = ib; cin = icin; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done, then one more edge so the caller lands in IDLE.
    task automatic wait_done();
        int k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        int k;
        fork
            monitor();
        join_none

        // Reset with start held high: nothing may start.
        rst_n = 1'b0; start = 1'b1; sub = 1'b0; a = 16'h1234; b = 16'h4321; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf",  32'(ovf),  32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy), 32'd0);

        // Directed add / subtract vectors.
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0); wait_done();
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0); wait_done();
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1); wait_done();
        issue(16'h0007, 16'h0007, 1'b1, 1'b0, 16'h000F, 1'b0, 1'b0); wait_done();
        issue(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0); wait_done();
        issue(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0); wait_done();
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1); wait_done();
        // cin must be ignored on subtract.
        issue(16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0); wait_done();

        // Handshake: start during RUN and during DONE is dropped.
        issue(16'h00FF, 16'h0101, 1'b0, 1'b0, 16'h0200, 1'b0, 1'b0);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("hs_done_seen", 32'(done), 32'd1);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("hs_idle_busy", 32'(busy), 32'd0);
        check("hs_sum_held",  32'(sum),  32'h0200);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1); wait_done();

        // Reset in RUN cycle 2: operation dropped, no done.
        a = 16'h1234; b = 16'h4321; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_sum",  32'(sum),  32'd0);
        check("mid_rst_cout", 32'(cout), 32'd0);
        check("mid_rst_ovf",  32'(ovf),  32'd0);
        repeat (8) @(posedge clk);
        #1;
        issue(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0); wait_done();

        repeat (2) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
